// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle ARM-subset control unit; CTRL_COND_EXEC_EN enables NZCV flags and conditional execution
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [2:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] enhanced_op,
    output logic [2:0] ALUControl,
    output logic [2:0] RegSrc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_MEMDT    = 4'd10
    } state_t;

    state_t     state_q, state_d, cur_s;
    logic       next_pc, branch, mem_w, reg_w, ir_write, alu_op;
    logic       no_write, cond_ex;
    logic [2:0] dp_ctl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_MEMDT;
                endcase
            end
            S_MEMADR:               state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD, S_MEMDT:       state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
            default:                state_d = S_FETCH;
        endcase
    end

    // Outputs present FETCH values while reset is held, whatever state_q holds.
    assign cur_s = reset ? S_FETCH : state_q;
    assign state = cur_s;

    always_comb begin
        next_pc     = 1'b0;
        branch      = 1'b0;
        mem_w       = 1'b0;
        reg_w       = 1'b0;
        ir_write    = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        alu_op      = 1'b0;
        enhanced_op = 2'b00;
        case (cur_s)
            S_FETCH: begin
                next_pc   = 1'b1;
                ir_write  = 1'b1;
                ResultSrc = 2'b10;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
            end
            S_DECODE: begin
                ResultSrc = 2'b10;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            S_ALUWB:  reg_w = 1'b1;
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMWR: begin
                mem_w  = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                reg_w     = 1'b1;
                ResultSrc = 2'b01;
            end
            S_BRANCH: begin
                branch    = 1'b1;
                ResultSrc = 2'b10;
                ALUSrcB   = 2'b01;
            end
            S_MEMDT: begin
                ALUSrcB     = 2'b01;
                enhanced_op = Funct[2:1];
            end
            default: ;
        endcase
    end

    // NoWrite depends only on cmd so it still gates the write-back in ALUWB,
    // where alu_op is already low; memory ops never carry a cmd field.
    always_comb begin
        dp_ctl   = 3'b000;
        no_write = 1'b0;
        case (Funct[4:1])
            4'b0100: dp_ctl = 3'b000;
            4'b0010: dp_ctl = 3'b001;
            4'b0000: dp_ctl = 3'b010;
            4'b1100: dp_ctl = 3'b011;
            4'b0001: dp_ctl = 3'b100;
            4'b1010: begin
                dp_ctl   = 3'b001;
                no_write = (Op == 2'b00);
            end
            default: no_write = (Op == 2'b00);
        endcase
    end

    assign ALUControl = alu_op ? dp_ctl : 3'b000;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b11, (Op == 2'b01) && !Funct[0], Op == 2'b10};

`ifdef CTRL_COND_EXEC_EN
    logic [3:0] flags_q, flags_d;

    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            3'b000:  cond_ex = flags_q[2];
            3'b001:  cond_ex = !flags_q[2];
            3'b010:  cond_ex = flags_q[1];
            3'b011:  cond_ex = !flags_q[1];
            3'b100:  cond_ex = flags_q[3];
            3'b101:  cond_ex = !flags_q[3];
            3'b110:  cond_ex = (flags_q[3] == flags_q[0]);
            default: cond_ex = 1'b1;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECUTER || state_q == S_EXECUTEI) && Funct[0] && cond_ex)
            flags_d = ALUFlags;
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end
`else
    logic unused_cond_inputs;
    assign unused_cond_inputs = ^{Cond, ALUFlags};
    assign cond_ex            = 1'b1;
`endif

    assign PCWrite  = !reset && (next_pc || (branch && cond_ex));
    assign IRWrite  = !reset && ir_write;
    assign RegWrite = !reset && reg_w && cond_ex && !no_write;
    assign MemWrite = !reset && mem_w && cond_ex;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [2:0] Cond;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, enhanced_op;
    logic [2:0] ALUControl, RegSrc;
    logic [3:0] state;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ResultSrc  (ResultSrc),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .enhanced_op(enhanced_op),
        .ALUControl (ALUControl),
        .RegSrc     (RegSrc),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mw, adr, srca;
        logic [1:0] rsrc, srcb, imm, enh;
        logic [2:0] aluc, regsrc;
    } exp_t;

    exp_t       sb_q[$];
    string      cur_name = "reset";
    int         n_tests  = 0;
    int         n_fail   = 0;
    logic [3:0] exp_flags = 4'b0000;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_name, tag, got, exp);
        end
    endtask

    function automatic logic cond_pass(input logic [2:0] c, input logic [3:0] f);
        logic r;
        r = 1'b1;
`ifdef CTRL_COND_EXEC_EN
        case (c)
            3'd0: r = f[2];
            3'd1: r = ~f[2];
            3'd2: r = f[1];
            3'd3: r = ~f[1];
            3'd4: r = f[3];
            3'd5: r = ~f[3];
            3'd6: r = ~(f[3] ^ f[0]);
            default: r = 1'b1;
        endcase
`else
        r = r | ^{c, f} | ~(^{c, f});
`endif
        return r;
    endfunction

    // Expected outputs per state, straight from the control table.
    function automatic exp_t model(input logic [3:0] st_in, input logic [1:0] op,
                                   input logic [5:0] fn, input logic cx, input logic rst);
        exp_t       e;
        logic [3:0] st;
        logic       nw;
        logic [2:0] dp;
        e  = '0;
        st = rst ? 4'd0 : st_in;
        nw = 1'b1;
        dp = 3'b000;
        case (fn[4:1])
            4'b0100: begin dp = 3'b000; nw = 1'b0; end
            4'b0010: begin dp = 3'b001; nw = 1'b0; end
            4'b0000: begin dp = 3'b010; nw = 1'b0; end
            4'b1100: begin dp = 3'b011; nw = 1'b0; end
            4'b0001: begin dp = 3'b100; nw = 1'b0; end
            4'b1010: dp = 3'b001;
            default: dp = 3'b000;
        endcase
        if (op != 2'b00) nw = 1'b0;
        e.st     = st;
        e.aluc   = (st == 4'd6 || st == 4'd7) ? dp : 3'b000;
        e.pcw    = (st == 4'd0) || (st == 4'd9 && cx);
        e.irw    = (st == 4'd0);
        e.rw     = (st == 4'd8 || st == 4'd4) && cx && !nw;
        e.mw     = (st == 4'd5) && cx;
        e.adr    = (st == 4'd3 || st == 4'd5);
        e.srca   = (st <= 4'd1);
        e.rsrc   = (st <= 4'd1 || st == 4'd9) ? 2'b10 : (st == 4'd4) ? 2'b01 : 2'b00;
        e.srcb   = (st <= 4'd1) ? 2'b10 :
                   (st == 4'd2 || st == 4'd7 || st == 4'd9 || st == 4'd10) ? 2'b01 : 2'b00;
        e.imm    = op;
        e.regsrc = {op == 2'b11, op == 2'b01 && !fn[0], op == 2'b10};
        e.enh    = (st == 4'd10) ? fn[2:1] : 2'b00;
        if (rst) begin
            e.pcw = 1'b0;
            e.irw = 1'b0;
            e.rw  = 1'b0;
            e.mw  = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [3:0] next_state(input logic [3:0] st, input logic [1:0] op,
                                              input logic [5:0] fn);
        case (st)
            4'd0: return 4'd1;
            4'd1: begin
                if (op == 2'b00) return fn[5] ? 4'd7 : 4'd6;
                if (op == 2'b01) return 4'd2;
                if (op == 2'b10) return 4'd9;
                return 4'd10;
            end
            4'd2:        return fn[0] ? 4'd3 : 4'd5;
            4'd3, 4'd10: return 4'd4;
            4'd6, 4'd7:  return 4'd8;
            default:     return 4'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("state",      {4'd0, state},       {4'd0, e.st});
            check("PCWrite",    {7'd0, PCWrite},     {7'd0, e.pcw});
            check("IRWrite",    {7'd0, IRWrite},     {7'd0, e.irw});
            check("RegWrite",   {7'd0, RegWrite},    {7'd0, e.rw});
            check("MemWrite",   {7'd0, MemWrite},    {7'd0, e.mw});
            check("AdrSrc",     {7'd0, AdrSrc},      {7'd0, e.adr});
            check("ALUSrcA",    {7'd0, ALUSrcA},     {7'd0, e.srca});
            check("ResultSrc",  {6'd0, ResultSrc},   {6'd0, e.rsrc});
            check("ALUSrcB",    {6'd0, ALUSrcB},     {6'd0, e.srcb});
            check("ImmSrc",     {6'd0, ImmSrc},      {6'd0, e.imm});
            check("enhanced",   {6'd0, enhanced_op}, {6'd0, e.enh});
            check("ALUControl", {5'd0, ALUControl},  {5'd0, e.aluc});
            check("RegSrc",     {5'd0, RegSrc},      {5'd0, e.regsrc});
        end
    end

    // Called just after a rising edge with the DUT in FETCH; abort_at >= 0 asserts
    // reset for one cycle at that step of the instruction.
    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] fn,
                             input logic [2:0] cnd, input logic [3:0] af, input int abort_at);
        logic [3:0] st;
        logic       cx;
        int         n;
        st       = 4'd0;
        n        = 0;
        cur_name = name;
        Op       = op;
        Funct    = fn;
        Cond     = cnd;
        ALUFlags = af;
        do begin
            if (n == abort_at) begin
                reset = 1'b1;
                sb_q.push_back(model(st, op, fn, 1'b0, 1'b1));
                @(posedge clk);
                #1;
                reset     = 1'b0;
                exp_flags = 4'b0000;
                return;
            end
            cx = cond_pass(cnd, exp_flags);
            sb_q.push_back(model(st, op, fn, cx, 1'b0));
            if ((st == 4'd6 || st == 4'd7) && fn[0] && cx) exp_flags = af;
            st = next_state(st, op, fn);
            n++;
            @(posedge clk);
            #1;
        end while (st != 4'd0);
    endtask

    initial begin
        reset    = 1'b1;
        Op       = 2'b00;
        Funct    = 6'b000000;
        Cond     = 3'b111;
        ALUFlags = 4'b0000;
        @(posedge clk);
        #1;
        repeat (2) begin
            sb_q.push_back(model(4'd0, Op, Funct, 1'b1, 1'b1));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        run_instr("LDR",        2'b01, 6'b000001, 3'b111, 4'b0000, -1);
        run_instr("STREQ_z0",   2'b01, 6'b000000, 3'b000, 4'b0000, -1);
        run_instr("ADDS_imm",   2'b00, 6'b101001, 3'b111, 4'b0100, -1);
        run_instr("STREQ_z1",   2'b01, 6'b000000, 3'b000, 4'b0000, -1);
        run_instr("BEQ_taken",  2'b10, 6'b000000, 3'b000, 4'b0000, -1);
        run_instr("CMP",        2'b00, 6'b010101, 3'b111, 4'b0000, -1);
        run_instr("BEQ_not",    2'b10, 6'b000000, 3'b000, 4'b0000, -1);
        run_instr("BNE",        2'b10, 6'b000000, 3'b001, 4'b0000, -1);
        run_instr("MEMDT",      2'b11, 6'b000100, 3'b111, 4'b0000, -1);
        run_instr("SUB",        2'b00, 6'b000100, 3'b111, 4'b1111, -1);
        run_instr("AND",        2'b00, 6'b000000, 3'b111, 4'b0000, -1);
        run_instr("ORR",        2'b00, 6'b011000, 3'b111, 4'b0000, -1);
        run_instr("EOR_imm",    2'b00, 6'b100010, 3'b111, 4'b0000, -1);
        run_instr("UNDEF_cmd",  2'b00, 6'b011110, 3'b111, 4'b0000, -1);
        run_instr("ADDEQ_fail", 2'b00, 6'b001000, 3'b000, 4'b0000, -1);
        run_instr("SUBS_neg",   2'b00, 6'b000101, 3'b111, 4'b1000, -1);
        run_instr("BMI",        2'b10, 6'b000000, 3'b100, 4'b0000, -1);
        run_instr("BGE_fail",   2'b10, 6'b000000, 3'b110, 4'b0000, -1);
        run_instr("ADDS_z",     2'b00, 6'b101001, 3'b111, 4'b0100, -1);
        run_instr("LDR_abort",  2'b01, 6'b000001, 3'b111, 4'b0000, 3);
        run_instr("BEQ_after",  2'b10, 6'b000000, 3'b000, 4'b0000, -1);
        run_instr("STR_AL",     2'b01, 6'b100000, 3'b111, 4'b0000, -1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

- Control unit for the 8-bit multi-cycle ARM-subset `datapath`.
- Decodes `Op`/`Funct`/`Cond` from the instruction register and steps an 11-state Moore FSM.
- Holds the NZCV condition flags and drives every datapath control strobe.
- Together with `datapath` it forms the complete processor; it replaces the hand-written control stimulus used in datapath benches.

## Interface
Parameters:
- none (state encoding is fixed, see Operation).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Op` in 2: instruction class; 00 data-processing, 01 memory, 10 branch, 11 enhanced memory-data-transfer.
- `Funct` in 6: for data-processing, [5]=I, [4:1]=cmd, [0]=S; for memory, [5]=~I, [0]=L; for Op=11, [2:1]=enhanced mode.
- `Cond` in 3: condition code (see Operation).
- `ALUFlags` in 4: {N,Z,C,V} from the ALU in the current cycle.
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite`, `AdrSrc`, `ALUSrcA` out 1 each: datapath strobes and selects.
- `ResultSrc`, `ALUSrcB`, `ImmSrc`, `enhanced_op` out 2 each.
- `ALUControl` out 3.
- `RegSrc` out 3.
- `state` out 4: current FSM state, for debug and verification.

## Operation
State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, MEMDT=10.
- Codes 11–15 are illegal and go to FETCH on the next edge.

Transitions:
- FETCH→DECODE.
- From DECODE, by `Op`:
  - Op=00: Funct[5]=1→EXECUTEI, else EXECUTER.
  - Op=01→MEMADR.
  - Op=10→BRANCH.
  - Op=11→MEMDT.
- MEMADR: L=1→MEMRD, else MEMWR.
- MEMRD→MEMWB; MEMDT→MEMWB.
- EXECUTER/EXECUTEI→ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH→FETCH.

Per-state controls are listed as NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp. Any field not listed is 0.
- FETCH: NextPC=1, IRWrite=1, ResultSrc=10, ALUSrcA=1, ALUSrcB=10.
- DECODE: ResultSrc=10, ALUSrcA=1, ALUSrcB=10.
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- MEMADR: ALUSrcB=01.
- MEMWR: MemW=1, AdrSrc=1.
- MEMRD: AdrSrc=1.
- MEMWB: RegW=1, ResultSrc=01.
- BRANCH: Branch=1, ResultSrc=10, ALUSrcB=01.
- MEMDT: ALUSrcB=01; `enhanced_op`=Funct[2:1]. `enhanced_op`=00 in every other state.

Derived outputs:
- `ALUControl`: when ALUOp=0 → 000 (ADD). When ALUOp=1, by cmd:
  - 0100→000 (ADD)
  - 0010→001 (SUB)
  - 0000→010 (AND)
  - 1100→011 (ORR)
  - 0001→100 (EOR)
  - 1010 (CMP)→001 with NoWrite=1
  - any other cmd→000 with NoWrite=1
- `ImmSrc`=`Op`.
- `RegSrc`={Op==11, Op==01 && !L, Op==10}.
- CondEx from the flag register:
  - 000 EQ: Z
  - 001 NE: !Z
  - 010 CS: C
  - 011 CC: !C
  - 100 MI: N
  - 101 PL: !N
  - 110 GE: N==V
  - 111 AL: 1
- `PCWrite` = NextPC | (Branch & CondEx).
- `RegWrite` = RegW & CondEx & !NoWrite.
- `MemWrite` = MemW & CondEx.
- Flag register: on the clock edge leaving EXECUTER or EXECUTEI, if S=1 and CondEx=1, flags ← `ALUFlags`.

## Timing
- Outputs are combinational from the state register, registered flags and the stable `Op`/`Funct`/`Cond` inputs; there are no output registers.
- Latency in cycles: LDR 5, STR 4, data-processing 4, MEMDT 4, B 3.
- While `reset` is high:
  - `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite` are forced to 0.
  - All other outputs show FETCH values; `state`=0.
- First edge after reset: state = FETCH. Flags reset to 0000.
- Reset asserted mid-instruction: the next edge goes to FETCH, the flags clear, and no write strobe is asserted during the reset cycle.
- A condition that fails still walks the full state sequence, with the write strobe suppressed.
- CMP with S=1 and condition passing updates the flags with no register write.

## Configuration
- `CTRL_COND_EXEC_EN` defined: flag register and CondEx logic as above.
- Not defined:
  - CondEx is tied to 1 and the flag register is removed.
  - `Cond` and `ALUFlags` are ignored.
  - All instructions execute unconditionally.

## Test plan
- Reset held 2 cycles, then released: `state` goes 0→1; `PCWrite`/`IRWrite` are 0 during reset and 1 in the first FETCH.
- LDR (Op=01, Funct=000001, Cond=111): states 0,1,2,3,4,0; `RegWrite`=1 only in state 4, with `ResultSrc`=01.
- STR (Op=01, Funct=000000) with Cond=000 and Z=0: states 0,1,2,5,0; `MemWrite` stays 0. With Z=1: `MemWrite`=1 in state 5.
- ADDS immediate (Op=00, Funct=101001) with ALUFlags=0100: `ALUControl`=000 in state 7; flags=0100 after the edge; a following BEQ (Op=10, Cond=000) asserts `PCWrite` in state 9.
- CMP (Funct=010101): `ALUControl`=001; `RegWrite`=0 in ALUWB; flags updated.
- Op=11 with Funct[2:1]=10: states 0,1,10,4; `enhanced_op`=10 only in state 10.
